text_renderer: RTL

- Text-mode pixel generator directly downstream of the VGA timing generator (800x600 active area, pixel clock domain).
- Consumes pixh/pixv/dis_en plus hsync/vsync; fetches character+attribute words from video RAM and glyph rows from the font ROM.
- Produces 12-bit RGB with sync and display-enable delayed to stay pixel-aligned.
- Character cell is 8x16, giving a 100x37 grid; rows 592-599 are blank.

---
 rtl/text_renderer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: 8x16 cells on an 800x600 raster, VRAM -> font ROM -> palette.
// Optional blinking underline cursor enabled by defining TEXT_RENDERER_CURSOR_EN.
module text_renderer #(
  parameter int COLS = 100,
  parameter int ROWS = 37
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [9:0]  pixh,
  input  logic [9:0]  pixv,
  input  logic        dis_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
`ifdef TEXT_RENDERER_CURSOR_EN
  input  logic        cur_en,
  input  logic [6:0]  cur_col,
  input  logic [5:0]  cur_row,
`endif
  output logic [11:0] vram_addr,
  input  logic [15:0] vram_rdata,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_rdata,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  // Latency follows from the five-register chain E0..E4.
  localparam int LAT = 4;
  localparam logic [6:0] COLS_L = 7'(COLS);
  localparam logic [5:0] ROWS_L = 6'(ROWS);

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [3:0] lo;
    lo = i[3] ? 4'h5 : 4'h0;
    return {(i[2] ? 4'hA : 4'h0) + lo,
            (i[1] ? 4'hA : 4'h0) + lo,
            (i[0] ? 4'hA : 4'h0) + lo};
  endfunction

  logic [6:0]  col;
  logic [5:0]  row;
  logic        row_blank;
  logic        col_blank;
  logic [11:0] cell_addr;

  assign col       = pixh[9:3];
  assign row       = pixv[9:4];
  assign row_blank = (row >= ROWS_L);
  assign col_blank = (col >= COLS_L);
  // row*100 as row*64 + row*32 + row*4, no multiplier
  assign cell_addr = {row, 6'b0} + {1'b0, row, 5'b0} + {4'b0, row, 2'b0} + {5'b0, col};

  // Sync / enable delay lines: entry k holds the value sampled at edge Ek.
  logic [LAT:0] de_dly;
  logic [LAT:0] hs_dly;
  logic [LAT:0] vs_dly;

  logic [2:0] s1_xbit, s2_xbit, s3_xbit, s4_xbit;
  logic [3:0] s1_grow, s2_grow;
  logic       s1_blank, s2_blank, s3_blank, s4_blank;
  logic [3:0] s3_fg, s3_bg, s4_fg, s4_bg;

  logic       glyph_bit;
  logic       cursor_px;
  logic [3:0] pix_idx;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vram_addr <= '0;
      font_addr <= '0;
      rgb       <= '0;
      de_dly    <= '0;
      hs_dly    <= '1;
      vs_dly    <= '1;
      s1_xbit   <= '0;
      s2_xbit   <= '0;
      s3_xbit   <= '0;
      s4_xbit   <= '0;
      s1_grow   <= '0;
      s2_grow   <= '0;
      s1_blank  <= 1'b0;
      s2_blank  <= 1'b0;
      s3_blank  <= 1'b0;
      s4_blank  <= 1'b0;
      s3_fg     <= '0;
      s3_bg     <= '0;
      s4_fg     <= '0;
      s4_bg     <= '0;
    end else begin
      de_dly <= {de_dly[LAT-1:0], dis_en};
      hs_dly <= {hs_dly[LAT-1:0], hsync_in};
      vs_dly <= {vs_dly[LAT-1:0], vsync_in};

      // E0: address generation
      vram_addr <= row_blank ? 12'd0 : cell_addr;
      s1_xbit   <= pixh[2:0];
      s1_grow   <= pixv[3:0];
      s1_blank  <= row_blank | col_blank;

      // E1: RAM is reading
      s2_xbit  <= s1_xbit;
      s2_grow  <= s1_grow;
      s2_blank <= s1_blank;

      // E2: cell word available, launch font lookup
      font_addr <= {vram_rdata[7:0], s2_grow};
      s3_fg     <= vram_rdata[11:8];
      s3_bg     <= vram_rdata[15:12];
      s3_xbit   <= s2_xbit;
      s3_blank  <= s2_blank;

      // E3: ROM is reading
      s4_fg    <= s3_fg;
      s4_bg    <= s3_bg;
      s4_xbit  <= s3_xbit;
      s4_blank <= s3_blank;

      // E4: colour out
      rgb <= (de_dly[LAT-1] & ~s4_blank) ? pal(pix_idx) : 12'h000;
    end
  end

  // bit7 is the leftmost pixel, so the index is 7-x, i.e. ~x on 3 bits
  assign glyph_bit = font_rdata[~s4_xbit];
  assign pix_idx   = (glyph_bit | cursor_px) ? s4_fg : s4_bg;

`ifdef TEXT_RENDERER_CURSOR_EN
  logic       vs_prev;
  logic [5:0] frame_cnt;
  logic       s1_cur, s2_cur, s3_cur, s4_cur;
  logic [3:0] s3_grow, s4_grow;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vs_prev   <= 1'b1;
      frame_cnt <= '0;
      s1_cur    <= 1'b0;
      s2_cur    <= 1'b0;
      s3_cur    <= 1'b0;
      s4_cur    <= 1'b0;
      s3_grow   <= '0;
      s4_grow   <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in)
        frame_cnt <= frame_cnt + 6'd1;
      s1_cur  <= cur_en && (col == cur_col) && (row == cur_row);
      s2_cur  <= s1_cur;
      s3_cur  <= s2_cur;
      s4_cur  <= s3_cur;
      s3_grow <= s2_grow;
      s4_grow <= s3_grow;
    end
  end

  // Underline on glyph rows 14/15; visible during the first half of the 64-frame cycle
  assign cursor_px = s4_cur && (s4_grow[3:1] == 3'b111) && !frame_cnt[5];
`else
  assign cursor_px = 1'b0;
`endif

  assign de_out    = de_dly[LAT];
  assign hsync_out = hs_dly[LAT];
  assign vsync_out = vs_dly[LAT];

endmodule
